// File: rtl/somador_pkg.sv
// Shared definitions for the mixed-signedness adder arbiter.
//   CODIGO_* : operand interpretation codes carried with every request
//              (first letter = operand A, second letter = operand B,
//               S = signed, U = unsigned).
//   id_width : width of a requester index, never less than one bit.
package somador_pkg;

    localparam logic [1:0] CODIGO_SS = 2'b00;
    localparam logic [1:0] CODIGO_UU = 2'b01;
    localparam logic [1:0] CODIGO_US = 2'b10;
    localparam logic [1:0] CODIGO_SU = 2'b11;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/somador_misto.sv
// Combinational W-bit adder whose operands may each be signed or unsigned.
// Ports:
//   a, b    in   W   operands
//   codigo  in   2   interpretation code (see somador_pkg CODIGO_*)
//   soma    out  W   low W bits of the sum (wrap-around in every mode)
//   ovf     out  1   sum does not fit the range of the selected mode
module somador_misto
    import somador_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [1:0]   codigo,
    output logic [W-1:0] soma,
    output logic         ovf
);

    logic [W+1:0] a_ext;
    logic [W+1:0] b_ext;
    logic [W+1:0] soma_ext;

    // Two guard bits hold every possible sum of a signed and an unsigned
    // W-bit value exactly, so the range checks read the top bits directly.
    always_comb begin
        a_ext = {2'b00, a};
        b_ext = {2'b00, b};
        if (codigo == CODIGO_SS || codigo == CODIGO_SU) begin
            a_ext = {{2{a[W-1]}}, a};
        end
        if (codigo == CODIGO_SS || codigo == CODIGO_US) begin
            b_ext = {{2{b[W-1]}}, b};
        end

        soma_ext = a_ext + b_ext;
        soma     = soma_ext[W-1:0];

        case (codigo)
            // Signed result fits only if the three top bits agree.
            CODIGO_SS: ovf = !((soma_ext[W+1:W-1] == 3'b000) ||
                               (soma_ext[W+1:W-1] == 3'b111));
            CODIGO_UU: ovf = soma_ext[W];
            // Mixed modes target [0, 2^W-1]: negative or >= 2^W both overflow.
            default:   ovf = |soma_ext[W+1:W];
        endcase
    end

endmodule

// File: rtl/arbitro_somador_sinal.sv
// Round-robin arbiter sharing one mixed-signedness adder among NREQ
// requesters, with a single registered result slot on a valid/ready output.
// Ports:
//   clk, rst_n   clock and synchronous active-low reset
//   req_valid    in   NREQ     request i valid
//   req_ready    out  NREQ     request i accepted this cycle (one-hot or zero)
//   req_a/req_b  in   NREQ*W   operands of request i at [W*i +: W]
//   req_codigo   in   NREQ*2   interpretation code of request i at [2*i +: 2]
//   res_valid    out  1        result slot holds a result
//   res_ready    in   1        downstream takes the result
//   res_dado     out  W        sum, low W bits
//   res_id       out  ID_W     requester that produced res_dado
//   res_ovf      out  1        sum out of range for the selected mode
module arbitro_somador_sinal
    import somador_pkg::*;
#(
    parameter  int NREQ = 4,
    parameter  int W    = 8,
    localparam int ID_W = id_width(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    input  logic [NREQ*2-1:0] req_codigo,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [W-1:0]      res_dado,
    output logic [ID_W-1:0]   res_id,
    output logic              res_ovf
);

    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] grant;
    logic [ID_W-1:0] rr_next;
    logic            found;
    logic            aceita;
    logic            transfer;
    logic [W-1:0]    sel_a;
    logic [W-1:0]    sel_b;
    logic [1:0]      sel_codigo;
    logic [W-1:0]    soma;
    logic            ovf;

    // Search starts at rr_ptr and wraps, so the requester served last has
    // the lowest priority on the next round.
    always_comb begin
        found = 1'b0;
        grant = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req_valid[(int'(rr_ptr) + k) % NREQ]) begin
                found = 1'b1;
                grant = ID_W'((int'(rr_ptr) + k) % NREQ);
            end
        end
    end

    // The slot can take a new result when empty or when it is being drained
    // on this same edge, which gives one result per cycle without stalls.
    always_comb begin
        aceita    = !res_valid || res_ready;
        transfer  = rst_n && found && aceita;
        req_ready = '0;
        if (transfer) begin
            req_ready[grant] = 1'b1;
        end
        rr_next = (grant == ID_W'(NREQ - 1)) ? '0 : grant + 1'b1;
    end

    // Operand mux feeding the single shared adder.
    always_comb begin
        sel_a      = req_a[int'(grant) * W +: W];
        sel_b      = req_b[int'(grant) * W +: W];
        sel_codigo = req_codigo[int'(grant) * 2 +: 2];
    end

    somador_misto #(
        .W (W)
    ) u_somador (
        .a      (sel_a),
        .b      (sel_b),
        .codigo (sel_codigo),
        .soma   (soma),
        .ovf    (ovf)
    );

    // A new transfer overwrites the slot even if it is being popped on the
    // same edge; a pop alone only clears valid and keeps the payload.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_dado  <= '0;
            res_id    <= '0;
            res_ovf   <= 1'b0;
            rr_ptr    <= '0;
        end else if (transfer) begin
            res_valid <= 1'b1;
            res_dado  <= soma;
            res_id    <= grant;
            res_ovf   <= ovf;
            rr_ptr    <= rr_next;
        end else if (res_valid && res_ready) begin
            res_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_arbitro_somador_sinal.sv
// Self-checking bench for arbitro_somador_sinal (NREQ=4, W=8).
// A bench-side model of the arbiter and adder pushes expected results into a
// scoreboard queue whenever an accept is predicted; each scenario task pops
// and compares them after the accepting edge.
module tb_arbitro_somador_sinal;

    localparam int NREQ = 4;
    localparam int W    = 8;

    typedef struct packed {
        logic [7:0] dado;
        logic [1:0] id;
        logic       ovf;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [7:0]  req_codigo;
    logic        res_valid;
    logic        res_ready;
    logic [7:0]  res_dado;
    logic [1:0]  res_id;
    logic        res_ovf;

    res_t sb[$];
    res_t last_exp;
    int   total = 0;
    int   bad   = 0;
    int   model_ptr;
    bit   model_valid;

    always #5 clk = ~clk;

    arbitro_somador_sinal #(
        .NREQ (NREQ),
        .W    (W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_codigo (req_codigo),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_dado   (res_dado),
        .res_id     (res_id),
        .res_ovf    (res_ovf)
    );

    // Reference adder written with plain integer arithmetic.
    function automatic res_t model_add(input logic [7:0] a, input logic [7:0] b,
                                       input logic [1:0] cod, input logic [1:0] id);
        int   av;
        int   bv;
        int   s;
        res_t r;
        av = (cod == 2'b00 || cod == 2'b11) ? int'($signed(a)) : int'(a);
        bv = (cod == 2'b00 || cod == 2'b10) ? int'($signed(b)) : int'(b);
        s  = av + bv;
        r.dado = s[7:0];
        case (cod)
            2'b00:   r.ovf = (s < -128) || (s > 127);
            2'b01:   r.ovf = (s > 255);
            default: r.ovf = (s < 0) || (s > 255);
        endcase
        r.id = id;
        return r;
    endfunction

    // Samples req_ready, predicts the edge with the model (pushing any
    // expected result), then advances one clock and settles.
    task automatic clock_edge(output bit pushed, output logic [3:0] act_ready,
                              output logic [3:0] exp_ready);
        int w;
        bit found;
        bit slot;
        #1;
        act_ready = req_ready;
        found = 1'b0;
        w = 0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req_valid[(model_ptr + k) % NREQ]) begin
                found = 1'b1;
                w = (model_ptr + k) % NREQ;
            end
        end
        slot = !model_valid || res_ready;
        exp_ready = 4'b0000;
        pushed = 1'b0;
        if (!rst_n) begin
            model_valid = 1'b0;
            model_ptr = 0;
            sb.delete();
        end else if (found && slot) begin
            exp_ready[w] = 1'b1;
            sb.push_back(model_add(req_a[8*w +: 8], req_b[8*w +: 8],
                                   req_codigo[2*w +: 2], 2'(w)));
            model_ptr = (w + 1) % NREQ;
            model_valid = 1'b1;
            pushed = 1'b1;
        end else if (model_valid && res_ready) begin
            model_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = 4'b0000;
        res_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_ptr = 0;
        model_valid = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 4'b1111;
        res_ready = 1'b1;
        req_a = 32'h11223344;
        req_b = 32'h01010101;
        req_codigo = 8'h00;
        @(posedge clk);
        #1;
        total++;
        if (req_ready !== 4'b0000) begin
            bad++;
            $display("FAIL reset_req_ready got=%b want=0000", req_ready);
        end
        total++;
        if (res_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_res_valid got=%b want=0", res_valid);
        end
        total++;
        if (res_dado !== 8'h00) begin
            bad++;
            $display("FAIL reset_res_dado got=%h want=00", res_dado);
        end
        total++;
        if (res_id !== 2'd0) begin
            bad++;
            $display("FAIL reset_res_id got=%0d want=0", res_id);
        end
        total++;
        if (res_ovf !== 1'b0) begin
            bad++;
            $display("FAIL reset_res_ovf got=%b want=0", res_ovf);
        end
        req_valid = 4'b0000;
        rst_n = 1'b1;
        model_ptr = 0;
        model_valid = 1'b0;
        sb.delete();
    endtask

    task automatic test_modes();
        logic [7:0] ta[4]   = '{8'h7F, 8'hFF, 8'h05, 8'hFB};
        logic [7:0] tb_[4]  = '{8'h01, 8'h01, 8'hFB, 8'h03};
        logic [1:0] tc[4]   = '{2'b00, 2'b01, 2'b10, 2'b11};
        logic [7:0] td[4]   = '{8'h80, 8'h00, 8'h00, 8'hFE};
        logic       to[4]   = '{1'b1, 1'b1, 1'b0, 1'b1};
        bit         p;
        logic [3:0] ar;
        logic [3:0] er;
        res_t       e;
        do_reset();
        res_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_valid = 4'b0001;
            req_a = {24'h0, ta[i]};
            req_b = {24'h0, tb_[i]};
            req_codigo = {6'b0, tc[i]};
            clock_edge(p, ar, er);
            total++;
            if (ar !== er) begin
                bad++;
                $display("FAIL mode%0d_ready got=%b want=%b", i, ar, er);
            end
            if (p) begin
                e = sb.pop_front();
                last_exp = e;
                total++;
                if ({res_valid, res_dado, res_id, res_ovf} !== {1'b1, e.dado, e.id, e.ovf}) begin
                    bad++;
                    $display("FAIL mode%0d_sb got v=%b d=%h id=%0d o=%b want v=1 d=%h id=%0d o=%b",
                             i, res_valid, res_dado, res_id, res_ovf, e.dado, e.id, e.ovf);
                end
            end
            total++;
            if ({res_dado, res_ovf} !== {td[i], to[i]}) begin
                bad++;
                $display("FAIL mode%0d_value got d=%h o=%b want d=%h o=%b",
                         i, res_dado, res_ovf, td[i], to[i]);
            end
        end
        req_valid = 4'b0000;
        clock_edge(p, ar, er);
        total++;
        if (res_valid !== 1'b0) begin
            bad++;
            $display("FAIL drain_valid got=%b want=0", res_valid);
        end
        total++;
        if (res_dado !== last_exp.dado) begin
            bad++;
            $display("FAIL drain_hold got=%h want=%h", res_dado, last_exp.dado);
        end
    endtask

    task automatic test_fairness();
        bit         p;
        logic [3:0] ar;
        logic [3:0] er;
        res_t       e;
        do_reset();
        req_a = {8'd40, 8'd30, 8'd20, 8'd10};
        req_b = {8'hF0, 8'd200, 8'h81, 8'd7};
        req_codigo = 8'b11_10_01_00;
        req_valid = 4'b1111;
        res_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            clock_edge(p, ar, er);
            total++;
            if (ar !== er) begin
                bad++;
                $display("FAIL fair%0d_ready got=%b want=%b", k, ar, er);
            end
            if (p) begin
                e = sb.pop_front();
                last_exp = e;
                total++;
                if ({res_valid, res_dado, res_id, res_ovf} !== {1'b1, e.dado, e.id, e.ovf}) begin
                    bad++;
                    $display("FAIL fair%0d_sb got v=%b d=%h id=%0d o=%b want v=1 d=%h id=%0d o=%b",
                             k, res_valid, res_dado, res_id, res_ovf, e.dado, e.id, e.ovf);
                end
            end
            total++;
            if (res_id !== 2'(k % 4)) begin
                bad++;
                $display("FAIL fair%0d_id got=%0d want=%0d", k, res_id, k % 4);
            end
        end
    endtask

    // Continues from the fairness state: slot full with id 3, pointer at 0.
    task automatic test_backpressure();
        bit         p;
        logic [3:0] ar;
        logic [3:0] er;
        res_t       e;
        res_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            clock_edge(p, ar, er);
            total++;
            if (ar !== 4'b0000) begin
                bad++;
                $display("FAIL bp%0d_ready got=%b want=0000", k, ar);
            end
            total++;
            if ({res_valid, res_dado, res_id, res_ovf} !== {1'b1, last_exp.dado, last_exp.id, last_exp.ovf}) begin
                bad++;
                $display("FAIL bp%0d_hold got v=%b d=%h id=%0d o=%b want v=1 d=%h id=%0d o=%b",
                         k, res_valid, res_dado, res_id, res_ovf, last_exp.dado, last_exp.id, last_exp.ovf);
            end
        end
        res_ready = 1'b1;
        clock_edge(p, ar, er);
        total++;
        if (ar !== 4'b0001) begin
            bad++;
            $display("FAIL bp_release_ready got=%b want=0001", ar);
        end
        if (p) begin
            e = sb.pop_front();
            total++;
            if ({res_valid, res_dado, res_id, res_ovf} !== {1'b1, e.dado, e.id, e.ovf}) begin
                bad++;
                $display("FAIL bp_release_sb got v=%b d=%h id=%0d o=%b want v=1 d=%h id=%0d o=%b",
                         res_valid, res_dado, res_id, res_ovf, e.dado, e.id, e.ovf);
            end
        end
    endtask

    task automatic test_sparse_wrap();
        logic [3:0] vseq[4] = '{4'b0010, 4'b1010, 4'b1010, 4'b1111};
        logic [1:0] iseq[4] = '{2'd1, 2'd3, 2'd1, 2'd2};
        bit         p;
        logic [3:0] ar;
        logic [3:0] er;
        res_t       e;
        do_reset();
        req_a = {8'd4, 8'd3, 8'd2, 8'd1};
        req_b = {8'd40, 8'd30, 8'd20, 8'd10};
        req_codigo = 8'b01_01_01_01;
        res_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            req_valid = vseq[k];
            clock_edge(p, ar, er);
            total++;
            if (ar !== er) begin
                bad++;
                $display("FAIL wrap%0d_ready got=%b want=%b", k, ar, er);
            end
            if (p) begin
                e = sb.pop_front();
                total++;
                if ({res_valid, res_dado, res_id, res_ovf} !== {1'b1, e.dado, e.id, e.ovf}) begin
                    bad++;
                    $display("FAIL wrap%0d_sb got v=%b d=%h id=%0d o=%b want v=1 d=%h id=%0d o=%b",
                             k, res_valid, res_dado, res_id, res_ovf, e.dado, e.id, e.ovf);
                end
            end
            total++;
            if (res_id !== iseq[k]) begin
                bad++;
                $display("FAIL wrap%0d_id got=%0d want=%0d", k, res_id, iseq[k]);
            end
        end
    endtask

    task automatic test_reset_mid_op();
        bit         p;
        logic [3:0] ar;
        logic [3:0] er;
        res_t       e;
        do_reset();
        req_a = {8'd9, 8'd8, 8'd7, 8'd6};
        req_b = {8'd1, 8'd1, 8'd1, 8'd1};
        req_codigo = 8'h00;
        req_valid = 4'b0100;
        res_ready = 1'b0;
        clock_edge(p, ar, er);
        if (p) begin
            e = sb.pop_front();
        end
        rst_n = 1'b0;
        req_valid = 4'b1111;
        clock_edge(p, ar, er);
        total++;
        if (ar !== 4'b0000) begin
            bad++;
            $display("FAIL midrst_ready got=%b want=0000", ar);
        end
        total++;
        if (res_valid !== 1'b0) begin
            bad++;
            $display("FAIL midrst_valid got=%b want=0", res_valid);
        end
        rst_n = 1'b1;
        res_ready = 1'b1;
        clock_edge(p, ar, er);
        total++;
        if (ar !== 4'b0001) begin
            bad++;
            $display("FAIL midrst_restart_ready got=%b want=0001", ar);
        end
        if (p) begin
            e = sb.pop_front();
            total++;
            if ({res_valid, res_dado, res_id, res_ovf} !== {1'b1, e.dado, e.id, e.ovf}) begin
                bad++;
                $display("FAIL midrst_sb got v=%b d=%h id=%0d o=%b want v=1 d=%h id=%0d o=%b",
                         res_valid, res_dado, res_id, res_ovf, e.dado, e.id, e.ovf);
            end
        end
        total++;
        if (res_id !== 2'd0) begin
            bad++;
            $display("FAIL midrst_id got=%0d want=0", res_id);
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover got=%0d want=0", sb.size());
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 4'b0000;
        req_a = '0;
        req_b = '0;
        req_codigo = '0;
        res_ready = 1'b0;
        model_ptr = 0;
        model_valid = 1'b0;
        last_exp = '0;
        test_reset();
        test_modes();
        test_fairness();
        test_backpressure();
        test_sparse_wrap();
        test_reset_mid_op();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
